dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- Initiator side of the data-memory interface: the CPU pipeline issues load/store requests and this block sequences them onto the word-wide data memory.
- Supports byte, halfword and word loads (signed/unsigned) and stores.
- Sub-word stores use read-modify-write (RMW) on the word memory.
- Loads are aligned and extended before being returned to the pipeline.

Parameters:
- ADDR_LSB, 2, lowest word-index bit of the byte address.
- ADDR_MSB, 11, highest word-index bit; gives 1024 words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid; misaligned or reserved size.
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors.
- dm_dmwr  output  1  to memory: 1 write, 0 read.
- dm_wren  output  1  to memory: access enable, high during any memory cycle.
- dm_address  output  10  to memory: word index req_addr[11:2].
- dm_din  output  32  to memory: write word.
- dm_dout  input  32  from memory: updated at the rising edge where dm_dmwr=0.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1.
  - Reset mid-operation aborts the operation. No write is issued and no response is produced.
- dm_dmwr, dm_wren and dm_address are registered and change only on rising clk; dm_dmwr never toggles combinationally.
- Handshake and latching:
  - Accept on a rising edge with req_valid & req_ready.
  - All request fields are latched at accept; the inputs may change afterwards.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- Lane mapping is little-endian: byte offset k occupies bits 8k+7:8k.
- Address bits above ADDR_MSB are ignored, so addresses wrap modulo 4 KB.
- States:
  - IDLE: req_ready=1, dm_wren=0, dm_dmwr=0.
    - On accept with error: go RESP_ERR.
    - On accept, load: go LD_RD.
    - On accept, word store: go ST_WR.
    - On accept, sub-word store: go RMW_RD.
  - RESP_ERR: resp_valid=1, resp_err=1, no memory activity → IDLE.
  - LD_RD: dm_wren=1, dm_dmwr=0; memory samples at the closing edge → LD_DATA.
  - LD_DATA: dm_wren=0, resp_valid=1.
    - resp_rdata = lane selected by the latched offset, then sign- or zero-extended.
    - → IDLE.
  - RMW_RD: as LD_RD → ST_WR.
  - ST_WR: dm_wren=1, dm_dmwr=1; the memory writes at the closing edge; resp_valid=1 in this cycle → IDLE.
    - Word store: dm_din = latched wdata.
    - Byte store: dm_din = dm_dout with lane k replaced by wdata[7:0].
    - Half store: dm_din = dm_dout with bytes k and k+1 replaced by wdata[15:0].
- Latency, counted in cycles after the accept edge until resp_valid:
  - Error: 1 cycle.
  - Load: 2 cycles; the response appears in the second cycle.
  - Word store: 1 cycle.
  - Sub-word store: 2 cycles.
- Throughput: the next request is accepted at the edge ending the response cycle at the earliest; req_ready=0 in every non-IDLE state.
- req_valid held high while not ready: the request is not lost; the caller holds it.
- Back-to-back: a store followed immediately by a load to the same word returns the stored value, since the write commits before LD_RD.

Decomposition:
- Package dm_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the lane-extraction and lane-merge function prototypes.
- Sub-module dm_lane_fmt (combinational): load extract/extend and store merge, instantiated once.
- FSM and registers stay in dm_access_unit.

Test Plan:
- sw 0x11223344 @0x010, then lw @0x010 → resp_rdata 0x11223344 two cycles after accept; resp_err=0.
- Word 0x010 = 0x11223344, sb 0xAB @0x012 → memory word 0x11AB3344; lbu @0x012 → 0x000000AB; lb @0x012 → 0xFFFFFFAB.
- sh 0x8001 @0x016 onto word 0 → word 0x80010000; lh @0x016 → 0xFFFF8001; lhu → 0x00008001.
- lw @0x013, sh @0x011, and size=11 → resp_err=1 one cycle after accept; dm_wren stays 0; memory unchanged.
- Assert rst during ST_WR of sb, then release → no write occurs; old word intact; req_ready=1 next cycle; no resp_valid.
- Store 0x5 @0x1004 (wrap) → word index 1 written; lw @0x004 returns 0x00000005.

Source files
------------

// File: rtl/dm_access_pkg.sv
// ---------------------------------------------------------------------------
// dm_access_pkg
// Shared definitions for the data-memory access unit:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, SZ_RSVD)
//   - the sequencing FSM state enum
//   - lane helpers: alignment check, load lane extraction/extension,
//     store lane merge (little-endian, byte offset k -> bits 8k+7:8k)
// ---------------------------------------------------------------------------
package dm_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESP_ERR = 3'd1,
    ST_LD_RD    = 3'd2,
    ST_LD_DATA  = 3'd3,
    ST_RMW_RD   = 3'd4,
    ST_ST_WR    = 3'd5
  } dm_state_e;

  // True when the request cannot be served: reserved size or misaligned.
  function automatic logic request_error(input logic [1:0] size, input logic [1:0] offset);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          res = {24'h000000, shifted[7:0]};
        end else begin
          res = {{24{shifted[7]}}, shifted[7:0]};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          res = {16'h0000, shifted[15:0]};
        end else begin
          res = {{16{shifted[15]}}, shifted[15:0]};
        end
      end
      SZ_WORD: res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {offset, 3'b000};
        data = {24'h000000, wdata[7:0]} << {offset, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {offset, 3'b000};
        data = {16'h0000, wdata[15:0]} << {offset, 3'b000};
      end
      SZ_WORD: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
      default: begin
        mask = 32'h0000_0000;
        data = 32'h0000_0000;
      end
    endcase
    return (old_word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/dm_access_unit_lane_fmt.sv
// ---------------------------------------------------------------------------
// dm_lane_fmt
// Combinational lane formatter shared by the load and store paths.
// Ports:
//   rd_word_i  : word read from memory
//   wdata_i    : right-justified store data
//   offset_i   : byte offset within the word (addr[1:0])
//   size_i     : access size encoding
//   uns_i      : zero-extend loads when 1
//   ld_data_o  : extracted and extended load data
//   st_word_o  : merged word to write back
// ---------------------------------------------------------------------------
module dm_lane_fmt
  import dm_access_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  // Load lane extraction and store lane merge.
  always_comb begin
    ld_data_o = lane_extract(rd_word_i, offset_i, size_i, uns_i);
    st_word_o = lane_merge(rd_word_i, wdata_i, offset_i, size_i);
  end

endmodule

// File: rtl/dm_access_unit.sv
// ---------------------------------------------------------------------------
// dm_access_unit
// Initiator side of the data-memory interface. Accepts one load/store at a
// time from the pipeline and sequences it onto a word-wide synchronous
// memory. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : request fields, latched at accept
//   resp_valid/resp_err/resp_rdata  : one-cycle completion pulse
//   dm_dmwr/dm_wren/dm_address/dm_din : memory command (registered ctrl)
//   dm_dout                   : memory read data, valid after a read edge
// ---------------------------------------------------------------------------
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int ADDR_LSB = 2,
  parameter int ADDR_MSB = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic                         resp_err,
  output logic [31:0]                  resp_rdata,
  output logic                         dm_dmwr,
  output logic                         dm_wren,
  output logic [ADDR_MSB-ADDR_LSB:0]   dm_address,
  output logic [31:0]                  dm_din,
  input  logic [31:0]                  dm_dout
);

  localparam int AW = ADDR_MSB - ADDR_LSB + 1;

  dm_state_e state_q, state_d;

  // Latched request fields.
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  // Registered memory/handshake controls and their next values.
  logic          wren_q, wren_d;
  logic          dmwr_q, dmwr_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic          rerr_q, rerr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic        accept_s;
  logic        req_err_s;
  logic [31:0] ld_data_s;
  logic [31:0] st_word_s;

  // Address bits above the word index are deliberately discarded (4 KB wrap).
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr[31:ADDR_MSB+1];

  assign accept_s  = req_valid & ready_q;
  assign req_err_s = request_error(req_size, req_addr[1:0]);

  dm_lane_fmt u_lane_fmt (
    .rd_word_i (dm_dout),
    .wdata_i   (wdata_q),
    .offset_i  (off_q),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .ld_data_o (ld_data_s),
    .st_word_o (st_word_s)
  );

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_d = ST_RESP_ERR;
          end else if (!req_we) begin
            state_d = ST_LD_RD;
          end else if (req_size == SZ_WORD) begin
            state_d = ST_ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP_ERR: state_d = ST_IDLE;
      ST_LD_RD:    state_d = ST_LD_DATA;
      ST_LD_DATA:  state_d = ST_IDLE;
      ST_RMW_RD:   state_d = ST_ST_WR;
      ST_ST_WR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Control outputs are computed from the next state so they are glitch-free
  // flops aligned with the state they belong to.
  always_comb begin
    wren_d   = 1'b0;
    dmwr_d   = 1'b0;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    case (state_d)
      ST_IDLE:     ready_d = 1'b1;
      ST_RESP_ERR: begin
        rvalid_d = 1'b1;
        rerr_d   = 1'b1;
      end
      ST_LD_RD:    wren_d = 1'b1;
      ST_LD_DATA:  rvalid_d = 1'b1;
      ST_RMW_RD:   wren_d = 1'b1;
      ST_ST_WR: begin
        wren_d   = 1'b1;
        dmwr_d   = 1'b1;
        rvalid_d = 1'b1;
      end
      default:     ready_d = 1'b1;
    endcase
    if (accept_s) begin
      addr_d = req_addr[ADDR_MSB:ADDR_LSB];
    end else begin
      addr_d = addr_q;
    end
  end

  // State and control-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wren_q   <= 1'b0;
      dmwr_q   <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      wren_q   <= wren_d;
      dmwr_q   <= dmwr_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      addr_q   <= addr_d;
    end
  end

  // Request field capture at accept; inputs are free to change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end else begin
      size_q  <= size_q;
      uns_q   <= uns_q;
      off_q   <= off_q;
      wdata_q <= wdata_q;
    end
  end

  // Data paths depend on dm_dout, which only becomes valid at the edge that
  // enters LD_DATA / ST_WR, so they are decoded from the registered state.
  always_comb begin
    if (state_q == ST_LD_DATA) begin
      resp_rdata = ld_data_s;
    end else begin
      resp_rdata = 32'h0000_0000;
    end
    if (state_q == ST_ST_WR) begin
      dm_din = st_word_s;
    end else begin
      dm_din = 32'h0000_0000;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign dm_wren    = wren_q;
  assign dm_dmwr    = dmwr_q;
  assign dm_address = addr_q;

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dm_dmwr;
  logic        dm_wren;
  logic [9:0]  dm_address;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  dm_access_unit #(.ADDR_LSB(2), .ADDR_MSB(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .dm_dmwr      (dm_dmwr),
    .dm_wren      (dm_wren),
    .dm_address   (dm_address),
    .dm_din       (dm_din),
    .dm_dout      (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model: synchronous read and write on the rising edge.
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    dm_dout = 32'h0;
  end
  always @(posedge clk) begin
    if (dm_wren) begin
      if (dm_dmwr) mem[dm_address] <= dm_din;
      else         dm_dout <= mem[dm_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wren_cnt = 0;
  always @(negedge clk) if (dm_wren) wren_cnt++;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc_cyc;
  } exp_t;
  exp_t sb_q[$];

  // Response monitor: pops the scoreboard on each completion pulse.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("resp_err",   {31'd0, resp_err}, {31'd0, e.err});
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("latency",    cyc - e.acc_cyc + 1, e.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.err = exp_err; e.rdata = exp_rd; e.lat = lat; e.acc_cyc = cyc;
    sb_q.push_back(e);
    // Scramble inputs to show the request was latched.
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Wait until all outstanding responses have been seen, then past the
  // write-commit edge.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("resp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int wc;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_rerr", {31'd0, resp_err}, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_wren", {30'd0, dm_wren, dm_dmwr}, 32'd0);
    check_val("rst_addr_din", {22'd0, dm_address} | dm_din, 32'd0);
    rst = 1'b0;

    // sw / lw
    issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344, 1'b0, 32'h0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0, 32'h11223344, 2);
    drain();
    check_val("mem_sw", mem[4], 32'h11223344);

    // sb then back-to-back byte loads
    issue(1'b1, 2'b00, 1'b0, 32'h012, 32'hDEADBEAB, 1'b0, 32'h0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h012, 32'h0, 1'b0, 32'h000000AB, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h012, 32'h0, 1'b0, 32'hFFFFFFAB, 2);
    drain();
    check_val("mem_sb", mem[4], 32'h11AB3344);

    // sh onto a zero word, then signed/unsigned half loads
    issue(1'b1, 2'b01, 1'b0, 32'h016, 32'h12348001, 1'b0, 32'h0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h016, 32'h0, 1'b0, 32'hFFFF8001, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h016, 32'h0, 1'b0, 32'h00008001, 2);
    drain();
    check_val("mem_sh", mem[5], 32'h80010000);

    // Error cases: no memory activity, memory untouched
    wc = wren_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h011, 32'hFFFF, 1'b1, 32'h0, 1);
    issue(1'b1, 2'b11, 1'b0, 32'h010, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
    drain();
    check_val("err_no_wren", 32'(wren_cnt - wc), 32'd0);
    check_val("err_mem", mem[4], 32'h11AB3344);

    // Reset during ST_WR of a byte store: write must be aborted
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h011; req_wdata = 32'h000000CD;
    @(posedge clk);       // accept -> RMW_RD
    #1 req_valid = 1'b0;
    @(posedge clk);       // -> ST_WR
    #2 rst = 1'b1;
    @(negedge clk);
    check_val("rstop_rvalid", {31'd0, resp_valid}, 32'd0);
    check_val("rstop_wren", {31'd0, dm_wren}, 32'd0);
    @(posedge clk);
    #1;
    check_val("rstop_mem", mem[4], 32'h11AB3344);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rstop_ready", {31'd0, req_ready}, 32'd1);
    check_val("rstop_no_resp", {31'd0, resp_valid}, 32'd0);

    // Address wrap modulo 4 KB
    issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'h00000005, 1'b0, 32'h0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 1'b0, 32'h00000005, 2);
    drain();
    check_val("mem_wrap", mem[1], 32'h00000005);
    check_val("mem_wrap_w4", mem[4], 32'h11AB3344);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
